// File: rtl/led_pkg.sv
// Shared types and helpers for the LED strip frame sequencer.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    LATCH  = 3'd4
  } state_t;

  localparam int DEF_NUM_LEDS     = 60;
  localparam int DEF_BIT_CYCLES   = 61;    // 1220 ns per bit at 50 MHz
  localparam int DEF_LATCH_CYCLES = 3000;  // 60 us strip latch at 50 MHz

  // Frame RAM stores {R,G,B}; the strip expects {G,R,B} on the wire.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/led_strip_sequencer_pixel_scaler.sv
// Combinational per-channel brightness scale followed by RGB->GRB reorder.
module pixel_scaler
  import led_pkg::*;
(
  input  logic [23:0] i_rgb,
  input  logic [7:0]  i_brightness,
  output logic [23:0] o_grb
);

  logic [15:0] w_scale;
  logic [15:0] w_r_prod;
  logic [15:0] w_g_prod;
  logic [15:0] w_b_prod;

  // brightness+1 makes 255 an exact identity after the >>8
  assign w_scale  = {8'd0, i_brightness} + 16'd1;
  assign w_r_prod = {8'd0, i_rgb[23:16]} * w_scale;
  assign w_g_prod = {8'd0, i_rgb[15:8]}  * w_scale;
  assign w_b_prod = {8'd0, i_rgb[7:0]}   * w_scale;

  assign o_grb = rgb_to_grb({w_r_prod[15:8], w_g_prod[15:8], w_b_prod[15:8]});

endmodule

// File: rtl/led_strip_sequencer.sv
// Frame sequencer: fetches pixels, scales and reorders them, and holds each
// word for 24 bit periods before a low latch interval and a done pulse.
module led_strip_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_brightness,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic              o_pix_rd_en,
  input  logic [23:0]       i_pix_data,
  output logic [23:0]       o_data,
  output logic              o_sending_data,
  output logic              o_word_strobe,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int WORD_CYCLES = 24 * BIT_CYCLES;
  localparam int WCNT_W      = $clog2(WORD_CYCLES);
  localparam int LCNT_W      = $clog2(LATCH_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LATCH_CYCLES - 1);
  // With a one-cycle latch the done pulse coincides with entering LATCH.
  localparam logic FD_ON_ENTRY = (LATCH_CYCLES == 1);

  state_t            r_state;
  logic [7:0]        r_bright;
  logic [WCNT_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_idx;
  logic [LCNT_W-1:0] r_lcnt;
  logic [23:0]       r_next_word;
  logic [23:0]       r_data;
  logic [ADDR_W-1:0] r_pix_addr;
  logic              r_pix_rd_en;
  logic              r_sending;
  logic              r_word_strobe;
  logic              r_busy;
  logic              r_frame_done;
  logic [23:0]       w_scaled;

  // Single scaler shared by the first-word load and the wcnt==1 prefetch capture
  pixel_scaler u_scaler (
    .i_rgb        (i_pix_data),
    .i_brightness (r_bright),
    .o_grb        (w_scaled)
  );

  // Frame FSM with word/latch counters and all registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_bright      <= 8'd0;
      r_wcnt        <= '0;
      r_idx         <= '0;
      r_lcnt        <= '0;
      r_next_word   <= 24'd0;
      r_data        <= 24'd0;
      r_pix_addr    <= '0;
      r_pix_rd_en   <= 1'b0;
      r_sending     <= 1'b0;
      r_word_strobe <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_word_strobe <= 1'b0;
      r_frame_done  <= 1'b0;
      r_pix_rd_en   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bright    <= i_brightness;
            r_busy      <= 1'b1;
            r_pix_rd_en <= 1'b1;
            r_pix_addr  <= '0;
            r_state     <= FETCH0;
          end
        end
        FETCH0: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_data        <= w_scaled;
          r_sending     <= 1'b1;
          r_word_strobe <= 1'b1;
          r_wcnt        <= '0;
          r_idx         <= '0;
          // Prefetch pixel 1 so it is read during the first wcnt==0 cycle
          if (LAST_IDX != '0) begin
            r_pix_rd_en <= 1'b1;
            r_pix_addr  <= ADDR_W'(1);
          end
          r_state <= SEND;
        end
        SEND: begin
          if (r_wcnt == WCNT_W'(1)) begin
            r_next_word <= w_scaled;
          end
          if (r_wcnt == WCNT_LAST) begin
            r_wcnt <= '0;
            if (r_idx < LAST_IDX) begin
              r_data        <= r_next_word;
              r_idx         <= r_idx + ADDR_W'(1);
              r_word_strobe <= 1'b1;
              if ((r_idx + ADDR_W'(1)) < LAST_IDX) begin
                r_pix_rd_en <= 1'b1;
                r_pix_addr  <= r_idx + ADDR_W'(2);
              end
            end else begin
              r_sending    <= 1'b0;
              r_data       <= 24'd0;
              r_lcnt       <= '0;
              r_frame_done <= FD_ON_ENTRY;
              r_state      <= LATCH;
            end
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        LATCH: begin
          if (r_lcnt == LCNT_LAST) begin
            r_lcnt  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_lcnt       <= r_lcnt + LCNT_W'(1);
            r_frame_done <= ((r_lcnt + LCNT_W'(1)) == LCNT_LAST);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_pix_addr     = r_pix_addr;
  assign o_pix_rd_en    = r_pix_rd_en;
  assign o_data         = r_data;
  assign o_sending_data = r_sending;
  assign o_word_strobe  = r_word_strobe;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;

endmodule
